// File: rtl/max_pkg.sv
// Shared types and defaults for the streaming max controller and its compare slice.
package max_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_W = 4;
  localparam int MAX_N = 8;

  // Index width for n operands; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/max_cmp_core.sv
// Combinational unsigned a > b slice; the shared resource the controller schedules.
module max_cmp_core #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt
);

  assign gt = (a > b);

endmodule

// File: rtl/max_stream_ctrl.sv
// Per-frame maximum and first-occurrence index over a serial operand stream,
// using one shared compare slice and a valid/ready result handshake.
module max_stream_ctrl
  import max_pkg::*;
#(
  parameter int W     = MAX_W,
  parameter int N     = MAX_N,
  parameter int IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     max_q, max_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             in_ready_q, out_valid_q, busy_q;
  logic             gt;
  logic             accept;

  max_cmp_core #(.W(W)) u_cmp (
    .a  (in_data),
    .b  (max_q),
    .gt (gt)
  );

  // in_ready_q is only ever set while in LOAD, so it alone qualifies an accept.
  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          if (cnt_q == '0) begin
            max_d = in_data;
            idx_d = '0;
          end else if (gt) begin
            max_d = in_data;
            idx_d = cnt_q;
          end
          // cnt parks at N-1 on the final beat; it restarts only with the next frame.
          if (cnt_q == LAST) state_d = DONE;
          else               cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      max_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      in_ready_q  <= (state_d == LOAD);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_max   = max_q;
  assign out_idx   = idx_q;

endmodule

// File: tb/tb_max_stream_ctrl.sv
// Directed bench: a queue-based frame model is compared every cycle, and literal results pin each frame.
module tb_max_stream_ctrl;

  localparam int W = 4;
  localparam int N = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_max;
  logic [IDX_W-1:0] out_idx;
  logic             busy;

  int checks = 0;
  int failures = 0;

  max_stream_ctrl #(.W(W), .N(N), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 collecting beats, 2 result pending.
  int         m_mode = 0;
  logic [W-1:0] beats[$];
  int         frames_done = 0;
  int         cap_max = -1;
  int         cap_idx = -1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0;
      beats.delete();
    end else begin
      case (m_mode)
        0: if (start) begin m_mode = 1; beats.delete(); end
        1: if (in_valid) begin
             beats.push_back(in_data);
             if (beats.size() == N) m_mode = 2;
           end
        default: if (out_ready) m_mode = 0;
      endcase
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", int'(in_ready), int'(m_mode == 1));
      chk("out_valid", int'(out_valid), int'(m_mode == 2));
      chk("busy", int'(busy), int'(m_mode != 0));
      if (m_mode == 2) begin
        int em, ei;
        em = -1; ei = 0;
        for (int k = 0; k < beats.size(); k++)
          if (int'(beats[k]) > em) begin em = int'(beats[k]); ei = k; end
        chk("beats_in_frame", beats.size(), N);
        chk("out_max", int'(out_max), em);
        chk("out_idx", int'(out_idx), ei);
        if (out_valid && out_ready) begin
          cap_max = int'(out_max);
          cap_idx = int'(out_idx);
          frames_done++;
        end
      end
    end
  end

  logic [W-1:0] fd [N];

  // One frame: optional random gaps, result stall, start pulses in LOAD/DONE/handshake.
  task automatic run_frame(input bit gaps, input int stall, input bit poke_start,
                           input bit start_at_hs, input int exp_max, input int exp_idx,
                           input string tag);
    int i, guard;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    i = 0; guard = 0;
    while (i < N && guard < 200) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = fd[i];
      start    = poke_start && (i == 3);
      @(posedge clk); #1;
      if (in_valid) i++;
      guard++;
    end
    if (guard >= 200) chk({tag, "_beat_timeout"}, guard, 0);
    in_valid = 1'b0; start = 1'b0;
    repeat (stall) begin
      start = poke_start;
      @(posedge clk); #1;
    end
    out_ready = 1'b1; start = start_at_hs;
    @(posedge clk); #1;
    out_ready = 1'b0; start = 1'b0;
    chk({tag, "_max"}, cap_max, exp_max);
    chk({tag, "_idx"}, cap_idx, exp_idx);
    $display("frame %s: max=%0d idx=%0d frames=%0d", tag, cap_max, cap_idx, frames_done);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_max", int'(out_max), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Result latency: out_valid visible in the cycle right after the 8th accept.
    fd = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1; in_data = fd[k];
      @(posedge clk); #1;
      if (k < N - 1) chk("latency_early_valid", int'(out_valid), 0);
    end
    in_valid = 1'b0;
    chk("latency_valid", int'(out_valid), 1);
    chk("asc_max_lit", int'(out_max), 8);
    chk("asc_idx_lit", int'(out_idx), 7);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk("asc_done_frames", frames_done, 1);

    fd = '{4'd3, 4'd9, 4'd2, 4'd9, 4'd0, 4'd9, 4'd1, 4'd4};
    run_frame(1'b0, 0, 1'b0, 1'b0, 9, 1, "ties");

    fd = '{4'd2, 4'd11, 4'd5, 4'd14, 4'd14, 4'd3, 4'd0, 4'd7};
    run_frame(1'b1, 5, 1'b0, 1'b0, 14, 3, "gaps_stall");

    fd = '{default: 4'd0};
    run_frame(1'b0, 0, 1'b0, 1'b0, 0, 0, "all_zero");
    fd = '{default: 4'd15};
    run_frame(1'b0, 1, 1'b0, 1'b0, 15, 0, "all_max");

    fd = '{4'd6, 4'd1, 4'd12, 4'd3, 4'd12, 4'd10, 4'd0, 4'd2};
    run_frame(1'b1, 3, 1'b1, 1'b1, 12, 2, "start_poke");
    // start seen at the handshake must not launch a frame.
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_extra_frame_ready", int'(in_ready), 0);
    end
    chk("frames_after_poke", frames_done, 6);

    // Abort mid-frame with an asynchronous reset.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    fd = '{4'd7, 4'd3, 4'd12, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0};
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = fd[k];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("abort_in_ready", int'(in_ready), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_out_max", int'(out_max), 0);
    chk("abort_out_idx", int'(out_idx), 0);
    @(posedge clk); #1 rst = 1'b0;

    fd = '{4'd5, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd6};
    run_frame(1'b0, 0, 1'b0, 1'b0, 6, 7, "after_reset");
    chk("frames_total", frames_done, 7);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/max_stream_ctrl.md
# max_stream_ctrl

Sequential controller that schedules a single shared unsigned two-operand compare slice over a serial operand stream. It produces the maximum value and the index of its first occurrence once per frame of N operands. It sits upstream of the approximate max datapath partitions: it feeds the compare slice one operand per accepted beat and holds the running result between beats. Frames are started explicitly and results are returned over a valid/ready handshake.

## Interface
- W, default 4: operand width in bits, unsigned.
- N, default 8: operands per frame, N >= 2.
- IDX_W, default $clog2(N): index width.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame start request; sampled only in IDLE.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand accepted when in_valid && in_ready.
- in_data  in  W  operand.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_max  out  W  frame maximum.
- out_idx  out  IDX_W  index (0-based beat number) of first occurrence of maximum.
- busy  out  1  high in LOAD or DONE.

## Operation
- Reset is asynchronous and active-high. On reset: state=IDLE, cnt=0, max_r=0, idx_r=0, in_ready=0, out_valid=0, busy=0, out_max=0, out_idx=0.
- States: IDLE, LOAD, DONE.
- IDLE: when start=1, go to LOAD with cnt=0.
- LOAD: in_ready=1. On each accept:
  - if cnt==0, max_r<=in_data and idx_r<=0;
  - otherwise, if cmp_gt(in_data, max_r), max_r<=in_data and idx_r<=cnt.
  - cnt increments on every accept.
  - The accept at cnt==N-1 moves the block to DONE and applies the final update in the same edge.
- Ties keep the earlier index (strict greater-than). Comparison is unsigned and full width W, with no truncation.
- DONE: out_valid=1 and out_max=max_r, out_idx=idx_r, both held stable until the handshake. When out_ready=1, go to IDLE. max_r and idx_r keep their values; out_valid drops.
- start outside IDLE is ignored and is not queued. in_valid outside LOAD is ignored and nothing is accepted.
- If start=1 in the same cycle as the DONE handshake, it is not honoured; start is sampled again in IDLE on the next cycle.
- cnt wraps only through the frame restart; it never exceeds N-1.
- Reset mid-frame aborts the frame. The partial result is discarded and out_valid=0 immediately (asynchronous).

## Timing
- in_ready is registered state decode: high from the cycle after start is sampled in IDLE.
- Result latency: out_valid rises on the clock edge that accepts operand N-1, i.e. it is visible in the following cycle.
- Minimum frame time is N+2 cycles: start, N accepts, 1 result cycle with out_ready=1. Back-to-back frames need one IDLE cycle between them.
- in_ready and out_valid are never high together.
- The compare path is combinational within one cycle: in_data to cmp_gt to max_r/idx_r.

## Structure
- Package max_pkg holds:
  - the state_t enum (IDLE, LOAD, DONE);
  - default constants MAX_W=4 and MAX_N=8;
  - a function computing IDX_W.
- Sub-module max_cmp_core: purely combinational unsigned a>b comparator of width W, output gt. This slice is the shared resource the controller schedules, and it is replaceable by an approximate variant.
- The controller holds the FSM, cnt, max_r and idx_r.

## Test plan
- Ascending frame with N=8, W=4, data 1,2,3,4,5,6,7,8: out_max=8, out_idx=7; out_valid one cycle after the 8th accept.
- Ties: data 3,9,2,9,0,9,1,4 gives out_max=9, out_idx=1 (first occurrence kept).
- Gaps and backpressure: in_valid toggled randomly and out_ready held low 5 cycles. Result is stable during the stall, out_valid stays high, and exactly 8 beats are accepted.
- All-zero and all-max frames: all 0 gives out_max=0, out_idx=0; all 15 gives out_max=15, out_idx=0.
- start pulsed in LOAD and DONE: ignored, with no extra frame. start during the DONE handshake is not honoured; a new frame starts only from a start seen in IDLE.
- Reset asserted after 4 accepts: all outputs return to 0 asynchronously and the state is IDLE. A fresh frame 5,1,1,1,1,1,1,6 then gives out_max=6, out_idx=7.
